display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 115 +++++++++++
 tb/tb_display_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 8-digit display scanner: alternates an all-dark gap with a per-digit dwell,
// applies leading-zero suppression from a per-frame BCD snapshot and PWM brightness.
module display_scan_ctrl #(
   parameter int DIV_W     = 16,
   parameter int BLANK_CYC = 4
) (
   input  logic             clk_scan,
   input  logic             scancnt_reset_n,
   input  logic [DIV_W-1:0] scan_div,
   input  logic [31:0]      bcd_bus,
   input  logic [7:0]       digit_en,
   input  logic             lz_suppress,
   input  logic [2:0]       brightness,
   output logic [2:0]       digit_idx,
   output logic [3:0]       digit_bcd,
   output logic [7:0]       display_dig_sel,
   output logic             seg_blank,
   output logic             frame_done
);

   typedef enum logic {BLANK = 1'b0, DWELL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [7:0]       blank_cnt_q, blank_cnt_d;
   logic [DIV_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [DIV_W-1:0] dwell_len_q, dwell_len_d;
   logic [2:0]       pwm_cnt_q;
   logic [2:0]       idx_q, idx_d;
   logic [31:0]      snap_q, snap_d;
   logic [7:0]       sel_q, sel_d;
   logic             blank_q;
   logic             frame_q, frame_d;
   logic [3:0]       bcd_q, bcd_d;
   logic [7:0]       suppressed;
   logic             lit;

   // A digit is a leading zero when it and every more significant snapshot digit are 0.
   assign suppressed[0] = 1'b0;
   for (genvar gi = 1; gi < 8; gi++) begin : g_supp
      assign suppressed[gi] = lz_suppress & (snap_q[31:4*gi] == '0);
   end

   always_comb begin
      state_d     = state_q;
      blank_cnt_d = blank_cnt_q;
      dwell_cnt_d = dwell_cnt_q;
      dwell_len_d = dwell_len_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      frame_d     = 1'b0;
      case (state_q)
         BLANK: begin
            if (blank_cnt_q == 8'(BLANK_CYC - 1)) begin
               state_d     = DWELL;
               blank_cnt_d = '0;
               dwell_cnt_d = '0;
               dwell_len_d = scan_div;
               idx_d       = idx_q + 3'd1;
               if (idx_d == 3'd0) snap_d = bcd_bus;
            end else begin
               blank_cnt_d = blank_cnt_q + 8'd1;
            end
         end
         DWELL: begin
            if (dwell_cnt_q == dwell_len_q) begin
               state_d = BLANK;
               frame_d = (idx_q == 3'd7);
            end else begin
               dwell_cnt_d = dwell_cnt_q + DIV_W'(1);
            end
         end
         default: state_d = BLANK;
      endcase

      lit   = (state_q == DWELL) & digit_en[idx_q] & ~suppressed[idx_q] & (pwm_cnt_q <= brightness);
      sel_d = lit ? ~(8'd1 << idx_q) : 8'hFF;
      // Use next-state index/snapshot so digit_bcd stays aligned with digit_idx.
      bcd_d = snap_d[{idx_d, 2'b00} +: 4];
   end

   always_ff @(posedge clk_scan) begin
      if (!scancnt_reset_n) begin
         state_q     <= BLANK;
         blank_cnt_q <= '0;
         dwell_cnt_q <= '0;
         dwell_len_q <= '0;
         pwm_cnt_q   <= '0;
         idx_q       <= 3'd7;
         snap_q      <= '0;
         sel_q       <= 8'hFF;
         blank_q     <= 1'b1;
         bcd_q       <= '0;
         frame_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         blank_cnt_q <= blank_cnt_d;
         dwell_cnt_q <= dwell_cnt_d;
         dwell_len_q <= dwell_len_d;
         pwm_cnt_q   <= pwm_cnt_q + 3'd1;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         sel_q       <= sel_d;
         blank_q     <= ~lit;
         bcd_q       <= bcd_d;
         frame_q     <= frame_d;
      end
   end

   assign digit_idx       = idx_q;
   assign digit_bcd       = bcd_q;
   assign display_dig_sel = sel_q;
   assign seg_blank       = blank_q;
   assign frame_done      = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: cycle-level reference model, frame-measurement vector table,
// hand-written corner sequences and randomized stimulus.
module tb_display_scan_ctrl;
   localparam int BC = 2;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] sdiv;
   logic [31:0]   bcd;
   logic [7:0]    en;
   logic          lz;
   logic [2:0]    br;
   logic [2:0]    digit_idx;
   logic [3:0]    digit_bcd;
   logic [7:0]    dig_sel;
   logic          seg_blank;
   logic          frame_done;

   always #5 clk = ~clk;

   display_scan_ctrl #(.DIV_W(DW), .BLANK_CYC(BC)) dut (
      .clk_scan       (clk),
      .scancnt_reset_n(rst_n),
      .scan_div       (sdiv),
      .bcd_bus        (bcd),
      .digit_en       (en),
      .lz_suppress    (lz),
      .brightness     (br),
      .digit_idx      (digit_idx),
      .digit_bcd      (digit_bcd),
      .display_dig_sel(dig_sel),
      .seg_blank      (seg_blank),
      .frame_done     (frame_done)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: phase is either dark or dwelling, with cycles left in that phase.
   bit          m_dark;
   int          m_left;
   int          m_idx;
   logic [31:0] m_snap;
   int          m_pwm;
   logic [2:0]  e_idx;
   logic [3:0]  e_bcd;
   logic [7:0]  e_sel;
   logic        e_blank;
   logic        e_fd;

   function automatic bit m_supp(int i);
      return lz && (i != 0) && ((m_snap >> (4 * i)) == 32'd0);
   endfunction

   task automatic model_step();
      bit         lit;
      logic [7:0] one_hot;
      if (!rst_n) begin
         m_dark = 1'b1; m_left = BC; m_idx = 7; m_snap = '0; m_pwm = 0;
         e_sel = 8'hFF; e_blank = 1'b1; e_fd = 1'b0;
      end else begin
         lit     = !m_dark && en[m_idx] && !m_supp(m_idx) && (m_pwm <= int'(br));
         one_hot = 8'd1 << m_idx;
         e_sel   = lit ? ~one_hot : 8'hFF;
         e_blank = !lit;
         e_fd    = !m_dark && (m_idx == 7) && (m_left == 1);
         m_pwm   = (m_pwm + 1) % 8;
         m_left--;
         if (m_left == 0) begin
            if (m_dark) begin
               m_dark = 1'b0;
               m_idx  = (m_idx + 1) % 8;
               m_left = int'(sdiv) + 1;
               if (m_idx == 0) m_snap = bcd;
            end else begin
               m_dark = 1'b1;
               m_left = BC;
            end
         end
      end
      e_idx = m_idx[2:0];
      e_bcd = m_snap[4*m_idx +: 4];
   endtask

   task automatic check(string name, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic tick();
      logic [16:0] got, want;
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      got  = {digit_idx, digit_bcd, dig_sel, seg_blank, frame_done};
      want = {e_idx, e_bcd, e_sel, e_blank, e_fd};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL model cycle %0d: got idx=%0d bcd=%h sel=%h blank=%b fd=%b want idx=%0d bcd=%h sel=%h blank=%b fd=%b",
                  cyc, digit_idx, digit_bcd, dig_sel, seg_blank, frame_done,
                  e_idx, e_bcd, e_sel, e_blank, e_fd);
      end
      total++;
      if (!$onehot0(~dig_sel)) begin
         bad++;
         $display("FAIL onehot_sel: got sel=%h want at most one low bit", dig_sel);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_idx(int target);
      int n = 0;
      while (int'(digit_idx) != target && n < 2000) begin
         tick();
         n++;
      end
      if (int'(digit_idx) != target) check("wait_idx_timeout", int'(digit_idx), target);
   endtask

   typedef struct {
      logic [31:0] bcd;
      logic [7:0]  en;
      logic        lz;
      logic [2:0]  br;
      int          div;
      logic [7:0]  exp_mask;
      int          exp_on;
      int          exp_period;
   } vec_t;

   vec_t vt[9];

   initial begin
      int on_cnt[8];
      int per, n, bcd_err;
      logic seen_low1;

      rst_n = 1'b0; sdiv = 16'd3; bcd = '0; en = 8'hFF; lz = 1'b0; br = 3'd7;

      vt[0] = '{32'h76543210, 8'hFF, 1'b0, 3'd7,  3, 8'hFF,  4,  48};
      vt[1] = '{32'h00000305, 8'hFF, 1'b1, 3'd7,  3, 8'h07,  4,  48};
      vt[2] = '{32'h00000305, 8'hFF, 1'b0, 3'd7,  3, 8'hFF,  4,  48};
      vt[3] = '{32'h12345678, 8'hFF, 1'b0, 3'd1, 15, 8'hFF,  4, 144};
      vt[4] = '{32'h12345678, 8'hFF, 1'b0, 3'd7, 15, 8'hFF, 16, 144};
      vt[5] = '{32'h98765432, 8'hA5, 1'b0, 3'd7,  3, 8'hA5,  4,  48};
      vt[6] = '{32'hA0000000, 8'hFF, 1'b1, 3'd7,  3, 8'hFF,  4,  48};
      vt[7] = '{32'h00000000, 8'hFF, 1'b1, 3'd7,  3, 8'h01,  4,  48};
      vt[8] = '{32'h00F00000, 8'hFF, 1'b1, 3'd3,  7, 8'h3F,  4,  80};

      // Reset state
      do_reset();
      check("rst_sel", int'(dig_sel), 8'hFF);
      check("rst_blank", int'(seg_blank), 1);
      check("rst_idx", int'(digit_idx), 7);
      check("rst_bcd", int'(digit_bcd), 0);
      check("rst_fd", int'(frame_done), 0);

      // Vector table: measure one steady-state frame per entry
      foreach (vt[v]) begin
         bcd = vt[v].bcd; en = vt[v].en; lz = vt[v].lz; br = vt[v].br; sdiv = DW'(vt[v].div);
         do_reset();
         n = 0;
         while (frame_done !== 1'b1 && n < 1000) begin tick(); n++; end
         check($sformatf("vec%0d_first_frame", v), int'(frame_done), 1);
         foreach (on_cnt[i]) on_cnt[i] = 0;
         per = 0; bcd_err = 0;
         do begin
            tick();
            per++;
            for (int i = 0; i < 8; i++) begin
               if (!dig_sel[i]) begin
                  on_cnt[i]++;
                  if (int'(digit_idx) != i || digit_bcd !== vt[v].bcd[4*i +: 4]) bcd_err++;
               end
            end
         end while (frame_done !== 1'b1 && per < 1000);
         check($sformatf("vec%0d_period", v), per, vt[v].exp_period);
         check($sformatf("vec%0d_bcd_errs", v), bcd_err, 0);
         for (int i = 0; i < 8; i++)
            check($sformatf("vec%0d_on_digit%0d", v, i), on_cnt[i], vt[v].exp_mask[i] ? vt[v].exp_on : 0);
      end

      // Mid-frame bcd change only shows from the next digit-0 dwell
      bcd = 32'h11111111; en = 8'hFF; lz = 1'b0; br = 3'd7; sdiv = 16'd3;
      do_reset();
      wait_idx(3);
      bcd = 32'h22222222;
      wait_idx(6);
      check("snap_old_d6", int'(digit_bcd), 1);
      wait_idx(7);
      check("snap_old_d7", int'(digit_bcd), 1);
      wait_idx(0);
      check("snap_new_d0", int'(digit_bcd), 2);

      // Reset pulse during digit 4 dwell
      wait_idx(4);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      check("midrst_sel", int'(dig_sel), 8'hFF);
      check("midrst_idx", int'(digit_idx), 7);
      check("midrst_blank", int'(seg_blank), 1);
      rst_n = 1'b1;
      n = 0;
      while (digit_idx != 3'd0 && n < 50) begin tick(); n++; end
      check("midrst_blank_len", n, BC);
      tick();
      check("midrst_first_lit", int'(dig_sel), 8'hFE);

      // Dwell-length change mid-dwell, with a partial enable mask
      en = 8'b1010_0101; sdiv = 16'd3; bcd = 32'h87654321;
      do_reset();
      seen_low1 = 1'b0;
      wait_idx(1);
      tick();
      sdiv = 16'd7;
      n = 1;
      while (digit_idx == 3'd1 && n < 100) begin
         if (!dig_sel[1]) seen_low1 = 1'b1;
         tick(); n++;
      end
      check("div_change_old_len", n, BC + 4);
      n = 0;
      while (digit_idx == 3'd2 && n < 100) begin tick(); n++; end
      check("div_change_new_len", n, BC + 8);
      check("disabled_digit1_low", int'(seen_low1), 0);

      // Randomized stimulus against the model
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 19) == 0) br = 3'($urandom);
         if ($urandom_range(0, 19) == 0) lz = 1'($urandom);
         if ($urandom_range(0, 19) == 0) en = 8'($urandom);
         if ($urandom_range(0, 49) == 0) sdiv = DW'($urandom_range(0, 5));
         if ($urandom_range(0, 29) == 0) bcd = $urandom >> ($urandom_range(0, 8) * 4);
         rst_n = ($urandom_range(0, 399) != 0);
         tick();
         rst_n = 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
